// File: rtl/gear_path_seq_pkg.sv
// Shared definitions for the gear path sequencer: gear-code ranges, class
// enum, class decode and FSM state encoding.
package gear_path_seq_pkg;

   localparam logic [7:0] GEAR_HS_LO = 8'h42;
   localparam logic [7:0] GEAR_HS_HI = 8'h48;
   localparam logic [7:0] GEAR_ML_LO = 8'h49;
   localparam logic [7:0] GEAR_ML_HI = 8'h4F;
   localparam logic [7:0] GEAR_ML_X1 = 8'h51;
   localparam logic [7:0] GEAR_ML_X2 = 8'h52;

   typedef enum logic [1:0] {
      CLS_NONE = 2'd0,
      CLS_ML   = 2'd1,
      CLS_HS   = 2'd2
   } gear_cls_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_RUN    = 2'd3
   } seq_state_e;

   function automatic gear_cls_e gear_class(input logic [7:0] code);
      gear_cls_e cls;
      if ((code >= GEAR_HS_LO) && (code <= GEAR_HS_HI)) begin
         cls = CLS_HS;
      end else if (((code >= GEAR_ML_LO) && (code <= GEAR_ML_HI)) ||
                   (code == GEAR_ML_X1) || (code == GEAR_ML_X2)) begin
         cls = CLS_ML;
      end else begin
         cls = CLS_NONE;
      end
      return cls;
   endfunction

endpackage

// File: rtl/gear_path_seq_debounce.sv
// Gear-code debounce: a new code must hold STABLE_CYC cycles before a
// one-cycle accept pulse is raised together with the accepted code.
module gear_debounce
   import gear_path_seq_pkg::*;
#(
   parameter int STABLE_CYC = 4
) (
   input  logic       clk163m84,
   input  logic       rstn_rr,
   input  logic [7:0] i_gear,
   input  logic [7:0] o_gear_cur,
   output logic       o_accept,
   output logic [7:0] o_gear_acc
);

   localparam logic [7:0] STABLE_L = 8'(STABLE_CYC);

   logic [7:0] cand_r;
   logic [7:0] cnt_r;
   logic [7:0] run_s;
   logic       hit_s;

   // Run length of the current code including this cycle; the pulse is
   // masked while it is high so the owner has a cycle to load o_gear_cur.
   always_comb begin
      run_s = 8'd1;
      if (i_gear == cand_r) begin
         if (cnt_r == 8'hFF) begin
            run_s = 8'hFF;
         end else begin
            run_s = cnt_r + 8'd1;
         end
      end else begin
         run_s = 8'd1;
      end
      hit_s = (i_gear != o_gear_cur) && (run_s >= STABLE_L) && !o_accept;
   end

   // Candidate tracking and registered accept pulse.
   always_ff @(posedge clk163m84 or negedge rstn_rr) begin
      if (!rstn_rr) begin
         cand_r     <= 8'h00;
         cnt_r      <= 8'd0;
         o_accept   <= 1'b0;
         o_gear_acc <= 8'h00;
      end else begin
         cand_r   <= i_gear;
         cnt_r    <= run_s;
         o_accept <= hit_s;
         if (hit_s) begin
            o_gear_acc <= i_gear;
         end
      end
   end

endmodule

// File: rtl/gear_path_seq.sv
// Gear path sequencer: debounced gear change -> FIFO flush -> settle -> ML/HS
// data routing. Optional drop statistics under GEAR_SEQ_DROP_STAT_EN.
module gear_path_seq
   import gear_path_seq_pkg::*;
#(
   parameter int STABLE_CYC = 4,
   parameter int RST_CYC    = 16,
   parameter int SETTLE_CYC = 32
) (
   input  logic        clk163m84,
   input  logic        rstn_rr,
   input  logic [7:0]  i_gear,
   input  logic [7:0]  i_data,
   input  logic        i_data_en,
   input  logic        i_fifo_full,
   output logic [7:0]  o_ml_data,
   output logic        o_ml_valid,
   output logic [7:0]  o_hs_data,
   output logic        o_hs_valid,
   output logic        o_fifo_rst,
   output logic [7:0]  o_gear_cur,
   output logic        o_busy,
   output logic [15:0] o_drop_cnt
);

   localparam logic [7:0] RST_LAST    = 8'(RST_CYC - 1);
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

   seq_state_e state_r;
   logic [7:0] phase_r;
   logic       acc_s;
   logic [7:0] acc_gear_s;
   gear_cls_e  cls_cur_s;

   assign cls_cur_s = gear_class(o_gear_cur);

   gear_debounce #(.STABLE_CYC(STABLE_CYC)) u_debounce (
      .clk163m84  (clk163m84),
      .rstn_rr    (rstn_rr),
      .i_gear     (i_gear),
      .o_gear_cur (o_gear_cur),
      .o_accept   (acc_s),
      .o_gear_acc (acc_gear_s)
   );

   // Sequencer FSM; acceptance preempts every state and restarts the flush.
   always_ff @(posedge clk163m84 or negedge rstn_rr) begin
      if (!rstn_rr) begin
         state_r    <= ST_IDLE;
         phase_r    <= 8'd0;
         o_gear_cur <= 8'h00;
         o_fifo_rst <= 1'b0;
         o_busy     <= 1'b0;
         o_ml_data  <= 8'h00;
         o_ml_valid <= 1'b0;
         o_hs_data  <= 8'h00;
         o_hs_valid <= 1'b0;
      end else if (acc_s) begin
         state_r    <= ST_FLUSH;
         phase_r    <= 8'd0;
         o_gear_cur <= acc_gear_s;
         o_fifo_rst <= 1'b1;
         o_busy     <= 1'b1;
         o_ml_data  <= 8'h00;
         o_ml_valid <= 1'b0;
         o_hs_data  <= 8'h00;
         o_hs_valid <= 1'b0;
      end else begin
         o_ml_data  <= 8'h00;
         o_ml_valid <= 1'b0;
         o_hs_data  <= 8'h00;
         o_hs_valid <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               o_fifo_rst <= 1'b0;
               o_busy     <= 1'b0;
            end
            ST_FLUSH: begin
               if (phase_r == RST_LAST) begin
                  phase_r    <= 8'd0;
                  o_fifo_rst <= 1'b0;
                  state_r    <= ST_SETTLE;
               end else begin
                  phase_r <= phase_r + 8'd1;
               end
            end
            ST_SETTLE: begin
               if (phase_r == SETTLE_LAST) begin
                  phase_r <= 8'd0;
                  o_busy  <= 1'b0;
                  state_r <= (cls_cur_s == CLS_NONE) ? ST_IDLE : ST_RUN;
               end else begin
                  phase_r <= phase_r + 8'd1;
               end
            end
            ST_RUN: begin
               case (cls_cur_s)
                  CLS_ML: begin
                     o_ml_data  <= i_data;
                     o_ml_valid <= i_data_en & ~i_fifo_full;
                  end
                  CLS_HS: begin
                     o_hs_data  <= i_data;
                     o_hs_valid <= i_data_en;
                  end
                  default: begin
                     state_r <= ST_IDLE;
                  end
               endcase
            end
            default: begin
               state_r    <= ST_IDLE;
               o_fifo_rst <= 1'b0;
               o_busy     <= 1'b0;
            end
         endcase
      end
   end

`ifdef GEAR_SEQ_DROP_STAT_EN
   logic        drop_s;
   logic [15:0] drop_cnt_r;

   // A strobe is dropped outside RUN, or in RUN ML while the tx FIFO is full.
   always_comb begin
      drop_s = 1'b0;
      if (i_data_en && ((state_r != ST_RUN) ||
                        ((cls_cur_s == CLS_ML) && i_fifo_full))) begin
         drop_s = 1'b1;
      end else begin
         drop_s = 1'b0;
      end
   end

   // Saturating drop counter, cleared whenever a flush starts.
   always_ff @(posedge clk163m84 or negedge rstn_rr) begin
      if (!rstn_rr) begin
         drop_cnt_r <= 16'h0000;
      end else if (acc_s) begin
         drop_cnt_r <= 16'h0000;
      end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
         drop_cnt_r <= drop_cnt_r + 16'd1;
      end
   end

   assign o_drop_cnt = drop_cnt_r;
`else
   assign o_drop_cnt = 16'h0000;
`endif

endmodule

// File: doc/gear_path_seq.md
GEAR_PATH_SEQ -- requirements
Module: gear_path_seq

Interface
REQ-001 Parameter STABLE_CYC, default 4: consecutive cycles a new gear code must hold before it is accepted (range 1-255).
REQ-002 Parameter RST_CYC, default 16: cycles o_fifo_rst stays high per flush (range 1-255).
REQ-003 Parameter SETTLE_CYC, default 32: cycles of write blanking after o_fifo_rst falls (range 1-255).
REQ-004 clk163m84  in  1  sole clock of the block.
REQ-005 rstn_rr  in  1  reset, asynchronous, active-low.
REQ-006 i_gear  in  8  raw down-gear code, quasi-static.
REQ-007 i_data  in  8  demodulated byte.
REQ-008 i_data_en  in  1  i_data qualifier.
REQ-009 i_fifo_full  in  1  full flag of the ML tx FIFO.
REQ-010 o_ml_data / o_ml_valid  out  8 / 1  ML-path byte and write strobe.
REQ-011 o_hs_data / o_hs_valid  out  8 / 1  HS-path byte and strobe.
REQ-012 o_fifo_rst  out  1  reset for the gear FIFO and the tx FIFO, active-high.
REQ-013 o_gear_cur  out  8  accepted gear code.
REQ-014 o_busy  out  1  high in FLUSH and SETTLE.
REQ-015 o_drop_cnt  out  16  count of dropped bytes (see Configuration).

Function
REQ-016 Class decode shall map codes 0x42-0x48 to HS, codes 0x49-0x4F, 0x51 and 0x52 to ML, and every other code (0x50 included) to NONE.
REQ-017 Debounce shall accept i_gear after it equals the same value different from o_gear_cur for STABLE_CYC consecutive cycles; any value change shall restart the count.
REQ-018 The FSM shall have states IDLE, FLUSH, SETTLE and RUN.
REQ-019 Any state, on acceptance: load o_gear_cur, clear the phase counter, go to FLUSH (a re-accept in FLUSH or SETTLE restarts the flush).
REQ-020 FLUSH: o_fifo_rst=1 for exactly RST_CYC cycles, then go to SETTLE.
REQ-021 SETTLE: o_fifo_rst=0 for SETTLE_CYC cycles, then go to RUN if the class of o_gear_cur is ML or HS, otherwise go to IDLE.
REQ-022 RUN, class ML: o_ml_data<=i_data and o_ml_valid<=i_data_en & !i_fifo_full, registered (1-cycle latency); HS outputs held 0.
REQ-023 RUN, class HS: o_hs_data<=i_data and o_hs_valid<=i_data_en, 1-cycle latency; ML outputs held 0.
REQ-024 IDLE, FLUSH, SETTLE: all data and valid outputs shall be 0, and every i_data_en is a drop.
REQ-025 RUN ML with i_fifo_full=1 and i_data_en=1 shall count as a drop; the byte is discarded, never stalled.
REQ-026 The valids in the last RUN cycle before FLUSH shall still reflect that cycle's input; valids shall be 0 from the first FLUSH cycle.

Reset
REQ-027 Reset values: state IDLE, o_gear_cur=0x00, debounce count 0, all data and valids 0, o_fifo_rst=0, o_busy=0, o_drop_cnt=0.
REQ-028 Reset mid-FLUSH or mid-RUN shall drop o_fifo_rst and all valids immediately (asynchronously).
REQ-029 After reset release, the first stable non-0x00 gear shall trigger a full FLUSH/SETTLE sequence.

Configuration
REQ-030 Macro GEAR_SEQ_DROP_STAT_EN defined: o_drop_cnt shall be a 16-bit saturating counter (holds at 0xFFFF) incremented per drop and cleared on entry to FLUSH.
REQ-031 Macro undefined: o_drop_cnt shall be tied to 0 and the counter logic shall not be instantiated.

Structure
REQ-032 The shared package shall hold the gear-code constants, the class enum (NONE/ML/HS), the class-decode function and the FSM state encoding.
REQ-033 The debounce shall be the sub-module gear_debounce (inputs i_gear and o_gear_cur; outputs an accept pulse and the accepted code).

Verification
REQ-034 Reset release, i_gear=0x45 held -> accept after 4 cycles; o_fifo_rst high 16 cycles, then 32 settle cycles, then RUN with HS valids and ML valids 0.
REQ-035 i_gear=0x4A, i_data=0xA5 with i_data_en pulsed in RUN -> o_ml_data=0xA5 and o_ml_valid=1 exactly one cycle later.
REQ-036 RUN ML, i_fifo_full=1, 10 strobes -> o_ml_valid stays 0 and o_drop_cnt=10 (macro on) or 0 (macro off).
REQ-037 i_gear toggles 0x4A/0x45 every 2 cycles -> no acceptance, state unchanged; then 0x45 held 4 cycles -> FLUSH.
REQ-038 i_gear=0x50 accepted from RUN -> FLUSH, SETTLE, then IDLE, with every output valid 0.
REQ-039 rstn_rr asserted on FLUSH cycle 5 -> o_fifo_rst=0 without a clock edge; after release, the gear is re-accepted and a full 16-cycle flush runs.
